// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared types for the UART debug command path.
//   - op_class_e : opcode class, encoded exactly as op[7:6]
//   - err_code_e : error codes reported on o_Err_Code
//   - framer_state_e : command framer FSM states
//   - cmd_frame_t : assembled command (opcode, address, data)
//   - PAYLOAD_BYTES : bytes per address or data payload word
package uart_dbg_pkg;

  localparam int PAYLOAD_BYTES = 4;

  typedef enum logic [1:0] {
    CLS_NONE      = 2'd0,
    CLS_ADDR      = 2'd1,
    CLS_ADDR_DATA = 2'd2,
    CLS_BAD       = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } framer_state_e;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_frame_t;

  // Class lives in the top two opcode bits.
  function automatic op_class_e op_class(input logic [7:0] op);
    return op_class_e'(op[7:6]);
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: inter-byte inactivity timer (down-counter).
//   i_Clock     system clock
//   i_Reset_n   async active-low reset
//   i_Clear     reload to a full interval (a byte was accepted / not timing)
//   i_Enable    count this cycle
//   o_Expire    high in the cycle the interval has fully elapsed while enabled
// The count is reloaded with TIMEOUT_CLKS-1 and expires when it sits at 0
// with enable high, i.e. on the TIMEOUT_CLKS-th enabled cycle after a clear.
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CLKS = 520830
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt;

  // Reset loads the full interval: "no time elapsed" for a down-counter.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n)                   cnt <= LOAD;
    else if (i_Clear)                 cnt <= LOAD;
    else if (i_Enable && cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign o_Expire = i_Enable && (cnt == '0);

endmodule

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles UART receive bytes into debugger command frames
// (opcode + 0/4/8 big-endian payload bytes) and offers them on valid/ready.
//   i_Clock, i_Reset_n      clock, async active-low reset
//   i_Rx_DV, i_Rx_Byte      one-cycle byte strobe from the UART receiver
//   i_Cmd_Ready             executor accepts the pending frame
//   o_Cmd_Valid/Op/Addr/Data  frame out, held stable until accepted
//   o_Busy                  frame in progress or pending
//   o_Err_Pulse/o_Err_Code  1 = bad opcode, 2 = timeout, 3 = overrun
// Build option: define UART_CMD_FRAMER_TIMEOUT_EN to add the inter-byte
// timeout (uart_idle_timer, error code 2). Without it partial frames wait
// indefinitely and TIMEOUT_CLKS has no effect.
module uart_cmd_framer
  import uart_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 520830
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Cmd_Ready,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Op,
  output logic [31:0] o_Cmd_Addr,
  output logic [31:0] o_Cmd_Data,
  output logic        o_Busy,
  output logic        o_Err_Pulse,
  output logic [1:0]  o_Err_Code
);

  localparam logic [1:0] LAST_BYTE = 2'(PAYLOAD_BYTES - 1);

  if (TIMEOUT_CLKS == 0) begin : g_bad_timeout
    $error("uart_cmd_framer: TIMEOUT_CLKS must be at least 1");
  end

  framer_state_e state, nxt_state;
  logic [1:0]    byte_cnt, nxt_cnt;
  cmd_frame_t    cmd, nxt_cmd;
  logic          err_pulse, nxt_err_pulse;
  err_code_e     err_code, nxt_err_code;
  logic          in_payload, timeout, start_op;

  assign in_payload = (state == ST_ADDR) || (state == ST_DATA);

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
  logic tmr_expire;

  // Any strobe reloads the timer; outside the payload states it stays loaded.
  uart_idle_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_idle_timer (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Clear   (i_Rx_DV || !in_payload),
    .i_Enable  (in_payload),
    .o_Expire  (tmr_expire)
  );

  // A byte landing in the expiry cycle wins over the timeout.
  assign timeout = tmr_expire && !i_Rx_DV;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = byte_cnt;
    nxt_cmd       = cmd;
    nxt_err_pulse = 1'b0;
    nxt_err_code  = err_code;
    start_op      = 1'b0;

    case (state)
      ST_IDLE: start_op = i_Rx_DV;
      ST_ADDR: begin
        if (i_Rx_DV) begin
          nxt_cmd.addr = {cmd.addr[23:0], i_Rx_Byte};
          nxt_cnt      = byte_cnt + 2'd1;
          if (byte_cnt == LAST_BYTE)
            nxt_state = (op_class(cmd.op) == CLS_ADDR_DATA) ? ST_DATA : ST_HOLD;
        end else if (timeout) begin
          nxt_state     = ST_IDLE;
          nxt_cnt       = '0;
          nxt_err_pulse = 1'b1;
          nxt_err_code  = ERR_TIMEOUT;
        end
      end
      ST_DATA: begin
        if (i_Rx_DV) begin
          nxt_cmd.data = {cmd.data[23:0], i_Rx_Byte};
          nxt_cnt      = byte_cnt + 2'd1;
          if (byte_cnt == LAST_BYTE) nxt_state = ST_HOLD;
        end else if (timeout) begin
          nxt_state     = ST_IDLE;
          nxt_cnt       = '0;
          nxt_err_pulse = 1'b1;
          nxt_err_code  = ERR_TIMEOUT;
        end
      end
      ST_HOLD: begin
        if (i_Cmd_Ready) begin
          nxt_state = ST_IDLE;
          // A byte in the handshake cycle is the next opcode, not an overrun.
          start_op  = i_Rx_DV;
        end else if (i_Rx_DV) begin
          nxt_err_pulse = 1'b1;
          nxt_err_code  = ERR_OVERRUN;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    if (start_op) begin
      nxt_cmd = '{op: i_Rx_Byte, addr: '0, data: '0};
      nxt_cnt = '0;
      case (op_class(i_Rx_Byte))
        CLS_NONE: nxt_state = ST_HOLD;
        CLS_BAD: begin
          nxt_state     = ST_IDLE;
          nxt_err_pulse = 1'b1;
          nxt_err_code  = ERR_OPCODE;
        end
        default:  nxt_state = ST_ADDR;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      cmd       <= '0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= nxt_state;
      byte_cnt  <= nxt_cnt;
      cmd       <= nxt_cmd;
      err_pulse <= nxt_err_pulse;
      err_code  <= nxt_err_code;
    end
  end

  assign o_Cmd_Valid = (state == ST_HOLD);
  assign o_Busy      = (state != ST_IDLE);
  assign o_Cmd_Op    = cmd.op;
  assign o_Cmd_Addr  = cmd.addr;
  assign o_Cmd_Data  = cmd.data;
  assign o_Err_Pulse = err_pulse;
  assign o_Err_Code  = err_code;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed + randomized bench for uart_cmd_framer.
// All stimulus is driven and all outputs are sampled on the falling edge.
// Expected frames are computed from the byte list alone: opcode = byte 0,
// address = bytes 1..4 big-endian, data = bytes 5..8 big-endian.
module tb_uart_cmd_framer;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        busy;
  logic        err_pulse;
  logic [1:0]  err_code;

  int vectors = 0;
  int miscompares = 0;

  uart_cmd_framer #(.TIMEOUT_CLKS(TMO)) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .i_Cmd_Ready (cmd_ready),
    .o_Cmd_Valid (cmd_valid),
    .o_Cmd_Op    (cmd_op),
    .o_Cmd_Addr  (cmd_addr),
    .o_Cmd_Data  (cmd_data),
    .o_Busy      (busy),
    .o_Err_Pulse (err_pulse),
    .o_Err_Code  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on a falling edge; strobes one byte across the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int maxgap);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0 && maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
      send(q[i]);
    end
  endtask

  function automatic logic [31:0] be32(input logic [7:0] q[$], input int base);
    return {q[base], q[base+1], q[base+2], q[base+3]};
  endfunction

  function automatic int payload_len(input logic [7:0] op);
    int cls;
    cls = int'(op) / 64;
    return (cls == 0) ? 0 : (cls == 1) ? 4 : 8;
  endfunction

  // Called right after the last byte: the frame must already be valid.
  task automatic expect_frame(input string tag, input logic [7:0] q[$], input int hold);
    logic [7:0]  eo;
    logic [31:0] ea, ed;
    int waited;
    eo = q[0];
    ea = (q.size() >= 5) ? be32(q, 1) : 32'h0;
    ed = (q.size() >= 9) ? be32(q, 5) : 32'h0;
    waited = 0;
    while (!cmd_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " latency"}, 96'(waited), 96'd0);
    chk({tag, " valid"}, 96'(cmd_valid), 96'd1);
    chk({tag, " fields"}, {24'h0, cmd_op, cmd_addr, cmd_data}, {24'h0, eo, ea, ed});
    chk({tag, " busy"}, 96'(busy), 96'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, {23'h0, cmd_valid, cmd_op, cmd_addr, cmd_data},
          {23'h0, 1'b1, eo, ea, ed});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({tag, " drop after accept"}, 96'(cmd_valid), 96'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outputs"},
        {22'h0, cmd_valid, cmd_op, cmd_addr, cmd_data, busy, err_pulse, err_code},
        96'h0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] op;
    int k;

    // Reset state
    @(negedge clk);
    chk_all_zero("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk_all_zero("post-reset idle");

    // No-payload opcode with ready already high: one-cycle valid
    cmd_ready = 1'b1;
    send(8'h05);
    chk("op05 valid", 96'(cmd_valid), 96'd1);
    chk("op05 fields", {24'h0, cmd_op, cmd_addr, cmd_data}, {24'h0, 8'h05, 64'h0});
    @(negedge clk);
    chk("op05 one cycle", 96'(cmd_valid), 96'd0);
    cmd_ready = 1'b0;

    // Address + data frame, back-to-back bytes, held 10 cycles
    q = '{8'h81, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(q, 0);
    chk("op81 known value", {cmd_addr, cmd_data}, {32'hDEADBEEF, 32'h01020304});
    expect_frame("op81", q, 10);

    // Bad opcode class
    send(8'hC0);
    chk("badop pulse", {busy, err_pulse, err_code}, {1'b0, 1'b1, 2'd1});
    @(negedge clk);
    chk("badop one cycle", {err_pulse, err_code}, {1'b0, 2'd1});
    q = '{8'h00};
    send_frame(q, 0);
    expect_frame("after badop", q, 1);

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
    // Silence of TIMEOUT_CLKS mid-frame
    send(8'h40);
    send(8'h12);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err_pulse && k < int'(TMO) + 8);
    chk("timeout latency", 96'(k), 96'(TMO));
    chk("timeout pulse", {busy, err_pulse, err_code}, {1'b0, 1'b1, 2'd2});
    q = '{8'h40, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_frame(q, 0);
    expect_frame("after timeout", q, 2);
    // Byte in the expiry cycle beats the timeout
    send(8'h40);
    idle(int'(TMO) - 1);
    send(8'hAB);
    chk("expiry-cycle byte", {busy, err_pulse}, {1'b1, 1'b0});
    send(8'hCD);
    send(8'hEF);
    send(8'h11);
    expect_frame("expiry-cycle frame", '{8'h40, 8'hAB, 8'hCD, 8'hEF, 8'h11}, 0);
`else
    // Without the timeout a partial frame waits indefinitely
    send(8'h40);
    send(8'h12);
    idle(3 * int'(TMO));
    chk("no timeout", {busy, err_pulse}, {1'b1, 1'b0});
    send(8'h34);
    send(8'h56);
    send(8'h78);
    expect_frame("late frame", '{8'h40, 8'h12, 8'h34, 8'h56, 8'h78}, 0);
`endif

    // Overrun while pending, then opcode in the handshake cycle
    send(8'h01);
    chk("pend valid", 96'(cmd_valid), 96'd1);
    send(8'h33);
    chk("overrun pulse", {err_pulse, err_code}, {1'b1, 2'd3});
    chk("overrun frame kept", {23'h0, cmd_valid, cmd_op, cmd_addr, cmd_data},
        {23'h0, 1'b1, 8'h01, 64'h0});
    cmd_ready = 1'b1;
    send(8'h07);
    cmd_ready = 1'b0;
    chk("handshake byte no err", {err_pulse, err_code}, {1'b0, 2'd3});
    expect_frame("handshake op07", '{8'h07}, 0);

    // Reset mid-frame
    send(8'h40);
    send(8'hAA);
    send(8'hBB);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midframe reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk_all_zero("after midframe reset");
    q = '{8'h42, 8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(q, 0);
    expect_frame("after reset frame", q, 1);

    // Randomized frames, gaps and acceptance delays
    for (int n = 0; n < 30; n++) begin
      op = 8'($urandom);
      if (op[7:6] == 2'b11) begin
        send(op);
        chk("rand badop", {busy, err_pulse, err_code}, {1'b0, 1'b1, 2'd1});
        idle(int'($urandom_range(2, 0)));
      end else begin
        q.delete();
        q.push_back(op);
        repeat (payload_len(op)) q.push_back(8'($urandom));
        send_frame(q, 3);
        chk("rand no err", 96'(err_pulse), 96'd0);
        expect_frame("rand", q, int'($urandom_range(3, 0)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
